fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter, computes the next PC from the sequential, branch, jump and jump-register paths, and drives the address of the byte-addressed, little-endian, combinational instruction memory. Captures the returned word into the IF/ID pipeline register for the decode stage. Honours stall and flush requests from the hazard unit and the branch logic in ID.

---
 rtl/fetch_stage_pkg.sv | 30 +++
 rtl/fetch_stage_if.sv | 39 +++
 rtl/fetch_stage_if_id_reg.sv | 23 ++
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: word width, next-PC
// select encodings, the NOP word and the IF/ID payload.
package fetch_stage_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned JIDX_W = 26;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_src_e;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] pc4;
    logic              valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{inst: NOP_WORD, pc4: '0, valid: 1'b0};

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch controls, redirect targets, instruction memory
// and IF/ID outputs. Counter signals exist only with FETCH_PERF_EN.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic                 stall;
  logic                 flush;
  logic [1:0]           pc_src;
  logic [WORD_W-1:0]    branch_target;
  logic [JIDX_W-1:0]    jump_index;
  logic [WORD_W-1:0]    jr_target;
  logic [WORD_W-1:0]    inst_adr;
  logic [WORD_W-1:0]    inst_data;
  logic [WORD_W-1:0]    pc;
  logic [WORD_W-1:0]    if_id_inst;
  logic [WORD_W-1:0]    if_id_pc4;
  logic                 if_id_valid;
`ifdef FETCH_PERF_EN
  logic [WORD_W-1:0]    fetch_count;
  logic [WORD_W-1:0]    bubble_count;
`endif

  modport master (
    input  stall, flush, pc_src, branch_target, jump_index, jr_target, inst_data,
    output inst_adr, pc, if_id_inst, if_id_pc4, if_id_valid
`ifdef FETCH_PERF_EN
    , fetch_count, bubble_count
`endif
  );

  modport slave (
    output stall, flush, pc_src, branch_target, jump_index, jr_target, inst_data,
    input  inst_adr, pc, if_id_inst, if_id_pc4, if_id_valid
`ifdef FETCH_PERF_EN
    , fetch_count, bubble_count
`endif
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear (bubble) has priority over hold.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= IF_ID_BUBBLE;
    end else if (clear) begin
      q <= IF_ID_BUBBLE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC mux and IF/ID capture.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc4;
  logic [WORD_W-1:0] next_pc;
  if_id_t            if_id_d;
  if_id_t            if_id_q;

  assign pc4 = pc_q + WORD_W'(4);

  // Jump region bits come from the PC+4 of the jump already sitting in IF/ID.
  always_comb begin
    next_pc = pc4;
    case (pc_src_e'(bus.pc_src))
      PC_SEQ:  next_pc = pc4;
      PC_BR:   next_pc = bus.branch_target;
      PC_J:    next_pc = {if_id_q.pc4[WORD_W-1:WORD_W-4], bus.jump_index, 2'b00};
      PC_JR:   next_pc = bus.jr_target;
      default: next_pc = pc4;
    endcase
  end

  // Flush does not touch the PC; only stall freezes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (!bus.stall) begin
      pc_q <= align_pc(next_pc);
    end
  end

  assign if_id_d = '{inst: bus.inst_data, pc4: pc4, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .hold  (bus.stall),
    .clear (bus.flush),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign bus.inst_adr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.if_id_inst  = if_id_q.inst;
  assign bus.if_id_pc4   = if_id_q.pc4;
  assign bus.if_id_valid = if_id_q.valid;

`ifdef FETCH_PERF_EN
  logic [WORD_W-1:0] fetch_q;
  logic [WORD_W-1:0] bubble_q;

  // Saturating counts of real fetches and of edges that produce or keep a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (!bus.flush && !bus.stall && (fetch_q != '1)) begin
        fetch_q <= fetch_q + WORD_W'(1);
      end
      if ((bus.flush || bus.stall) && (bubble_q != '1)) begin
        bubble_q <= bubble_q + WORD_W'(1);
      end
    end
  end

  assign bus.fetch_count  = fetch_q;
  assign bus.bubble_count = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a per-cycle reference model of the fetch rules.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory content is a unique, address-derived word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.inst_data = mem_word(bus.inst_adr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state updated once per rising edge.
  logic [31:0] m_pc = 32'h0, m_inst = 32'h0, m_pc4 = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_fetch = 32'h0, m_bubble = 32'h0;

  always @(posedge clk or posedge rst) begin : model
    logic [31:0] seq;
    logic [31:0] tgt;
    if (rst) begin
      m_pc <= 32'h0; m_inst <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
      m_fetch <= 32'h0; m_bubble <= 32'h0;
    end else begin
      seq = m_pc + 32'd4;
      if (bus.pc_src == PC_BR)      tgt = bus.branch_target;
      else if (bus.pc_src == PC_J)  tgt = {m_pc4[31:28], bus.jump_index, 2'b00};
      else if (bus.pc_src == PC_JR) tgt = bus.jr_target;
      else                          tgt = seq;
      tgt = tgt & 32'hFFFF_FFFC;
      if (!bus.stall) m_pc <= tgt;
      if (bus.flush) begin
        m_inst <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
      end else if (!bus.stall) begin
        m_inst <= mem_word(m_pc); m_pc4 <= seq; m_valid <= 1'b1;
      end
      if (!bus.flush && !bus.stall && m_fetch != 32'hFFFF_FFFF) m_fetch <= m_fetch + 32'd1;
      if ((bus.flush || bus.stall) && m_bubble != 32'hFFFF_FFFF) m_bubble <= m_bubble + 32'd1;
    end
  end

  // Compare every output against the model between edges.
  always @(negedge clk) begin
    if (!rst) begin
      chk("pc", bus.pc, m_pc);
      chk("inst_adr", bus.inst_adr, m_pc);
      chk("if_id_inst", bus.if_id_inst, m_inst);
      chk("if_id_pc4", bus.if_id_pc4, m_pc4);
      chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
`ifdef FETCH_PERF_EN
      chk("fetch_count", bus.fetch_count, m_fetch);
      chk("bubble_count", bus.bubble_count, m_bubble);
`endif
    end
  end

  // Present inputs at a falling edge, then advance through one rising edge.
  task automatic step(input logic st, input logic fl, input logic [1:0] src,
                      input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] jr);
    bus.stall = st; bus.flush = fl; bus.pc_src = src;
    bus.branch_target = bt; bus.jump_index = ji; bus.jr_target = jr;
    @(negedge clk);
  endtask

  task automatic seq_step();
    step(1'b0, 1'b0, PC_SEQ, 32'h0, 26'h0, 32'h0);
  endtask

  initial begin
    bus.stall = 1'b0; bus.flush = 1'b0; bus.pc_src = PC_SEQ;
    bus.branch_target = 32'h0; bus.jump_index = 26'h0; bus.jr_target = 32'h0;
    @(posedge clk); #2;
    chk("reset pc", bus.pc, 32'h0);
    chk("reset inst", bus.if_id_inst, 32'h0);
    chk("reset valid", 32'(bus.if_id_valid), 32'h0);
    @(negedge clk); rst = 1'b0;

    // First capture is the word at RESET_PC.
    seq_step();
    chk("first inst", bus.if_id_inst, 32'hC0DE_0000);
    seq_step();
    chk("pc at 8", bus.pc, 32'h8);

    // Two-cycle stall at pc=8 keeps word@4, then resumes with word@8.
    repeat (2) begin
      step(1'b1, 1'b0, PC_SEQ, 32'h0, 26'h0, 32'h0);
      chk("stall pc", bus.pc, 32'h8);
      chk("stall inst", bus.if_id_inst, 32'hC0DE_0004);
    end
    seq_step();
    chk("resume pc", bus.pc, 32'hC);
    chk("resume inst", bus.if_id_inst, 32'hC0DE_0008);
    chk("resume pc4", bus.if_id_pc4, 32'hC);
    seq_step();
    chk("pc at 16", bus.pc, 32'h10);

    // Taken branch with flush.
    step(1'b0, 1'b1, PC_BR, 32'h40, 26'h0, 32'h0);
    chk("branch pc", bus.pc, 32'h40);
    chk("branch bubble inst", bus.if_id_inst, 32'h0);
    chk("branch bubble valid", 32'(bus.if_id_valid), 32'h0);
    seq_step();
    chk("branch target inst", bus.if_id_inst, 32'hC0DE_0040);

    // Set up if_id_pc4 = 0x1000_0010, then jump and jr.
    step(1'b0, 1'b0, PC_JR, 32'h0, 26'h0, 32'h1000_000C);
    seq_step();
    chk("pre-jump pc4", bus.if_id_pc4, 32'h1000_0010);
    step(1'b0, 1'b0, PC_J, 32'h0, 26'h10, 32'h0);
    chk("jump pc", bus.pc, 32'h1000_0040);
    step(1'b0, 1'b0, PC_JR, 32'h0, 26'h0, 32'h23);
    chk("jr aligned pc", bus.pc, 32'h20);
    step(1'b0, 1'b0, PC_BR, 32'h47, 26'h0, 32'h0);
    chk("branch aligned pc", bus.pc, 32'h44);

    // Wrap-around from the top word.
    step(1'b0, 1'b0, PC_JR, 32'h0, 26'h0, 32'hFFFF_FFFF);
    chk("top pc", bus.pc, 32'hFFFF_FFFC);
    seq_step();
    chk("wrap pc", bus.pc, 32'h0);
    chk("wrap pc4", bus.if_id_pc4, 32'h0);
    chk("wrap inst", bus.if_id_inst, 32'h3F21_FFFC);

    // Stall and flush together: PC held, IF/ID bubble.
    seq_step();
    step(1'b1, 1'b1, PC_BR, 32'h80, 26'h0, 32'h0);
    chk("stall+flush pc", bus.pc, 32'h4);
    chk("stall+flush valid", 32'(bus.if_id_valid), 32'h0);
    chk("stall+flush inst", bus.if_id_inst, 32'h0);

    // Asynchronous reset between edges.
    seq_step();
    seq_step();
    #2 rst = 1'b1;
    #1;
    chk("async rst pc", bus.pc, 32'h0);
    chk("async rst inst", bus.if_id_inst, 32'h0);
    chk("async rst pc4", bus.if_id_pc4, 32'h0);
    chk("async rst valid", 32'(bus.if_id_valid), 32'h0);
    @(negedge clk); rst = 1'b0;

`ifdef FETCH_PERF_EN
    repeat (5) seq_step();
    step(1'b0, 1'b1, PC_SEQ, 32'h0, 26'h0, 32'h0);
    step(1'b1, 1'b0, PC_SEQ, 32'h0, 26'h0, 32'h0);
    chk("fetch_count 5", bus.fetch_count, 32'd5);
    chk("bubble_count 2", bus.bubble_count, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst fetch_count", bus.fetch_count, 32'd0);
    chk("rst bubble_count", bus.bubble_count, 32'd0);
    @(negedge clk); rst = 1'b0;
`endif
    repeat (3) seq_step();
    chk("final pc", bus.pc, 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
